// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM for the SISC datapath: fetch/decode/execute/mem/writeback with
// memory-ready wait states, a resumable HALT state and a saturating retired-instruction counter.
module ctrl_mc #(
  parameter int OP_W     = 4,
  parameter int MM_W     = 4,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OP_W-1:0]     opcode,
  input  logic [MM_W-1:0]     mm,
  input  logic [MM_W-1:0]     stat,
  input  logic                mem_rdy,
  input  logic                resume,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                rb_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                dm_we,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_sel,
  output logic                br_sel,
  output logic                pc_rst,
  output logic                halted,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instr_cnt
);

  typedef enum logic [2:0] {
    START0    = 3'd0,
    START1    = 3'd1,
    FETCH     = 3'd2,
    DECODE    = 3'd3,
    EXECUTE   = 3'd4,
    MEM       = 3'd5,
    WRITEBACK = 3'd6,
    HALT      = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);
  localparam logic [MM_W-1:0] MM_IMM = MM_W'(8);

  state_t cur_st, nxt_st;

  logic is_lod, is_str, is_alu, is_hlt, br_pos, br_neg, cc_hit, taken, imm;

  // bit1 = hold condition codes, bit0 = immediate operand
  function automatic logic [ALU_OP_W-1:0] alu_code(input logic hold, input logic im);
    logic [ALU_OP_W-1:0] c;
    c    = '0;
    c[1] = hold;
    c[0] = im;
    return c;
  endfunction

  assign is_lod = (opcode == OP_LOD);
  assign is_str = (opcode == OP_STR);
  assign is_alu = (opcode == OP_ALU);
  assign is_hlt = (opcode == OP_HLT);
  assign br_pos = (opcode == OP_BRA) || (opcode == OP_BRR);
  assign br_neg = (opcode == OP_BNE) || (opcode == OP_BNR);
  assign cc_hit = |(stat & mm);
  assign taken  = (br_pos && cc_hit) || (br_neg && !cc_hit);
  assign imm    = (mm == MM_IMM);

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      cur_st    <= START1;
      halted    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      cur_st <= nxt_st;
      halted <= (nxt_st == HALT);
      if (cur_st == DECODE && instr_cnt != {CNT_W{1'b1}})
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_st = START1;
    case (cur_st)
      START0:    nxt_st = START1;
      START1:    nxt_st = FETCH;
      FETCH:     nxt_st = mem_rdy ? DECODE : FETCH;
      DECODE:    nxt_st = is_hlt ? HALT : EXECUTE;
      EXECUTE:   nxt_st = MEM;
      MEM:       nxt_st = ((is_lod || is_str) && !mem_rdy) ? MEM : WRITEBACK;
      WRITEBACK: nxt_st = FETCH;
      HALT:      nxt_st = resume ? FETCH : HALT;
      default:   nxt_st = START1;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = alu_code(1'b1, 1'b0);
    dm_we    = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    case (cur_st)
      START0, START1: pc_rst = 1'b1;
      FETCH: begin
        ir_load  = mem_rdy;
        pc_write = mem_rdy;
      end
      DECODE: begin
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
        end
      end
      EXECUTE: begin
        if (is_alu) alu_op = alu_code(1'b0, imm);
        else if (is_lod || is_str) begin
          alu_op = alu_code(1'b1, 1'b1);
          rb_sel = is_str;
        end
      end
      MEM: begin
        if (is_alu) alu_op = alu_code(1'b1, imm);
        else if (is_lod || is_str) begin
          alu_op = alu_code(1'b1, 1'b1);
          rb_sel = is_str;
          dm_we  = is_str;
        end
      end
      WRITEBACK: begin
        if (is_alu) begin
          rf_we  = 1'b1;
          alu_op = alu_code(1'b1, imm);
        end else if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      HALT: alu_op = '0;
      default: pc_rst = 1'b1;
    endcase
  end

  assign state = cur_st;

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc; a second instance with a 2-bit counter covers saturation.
module tb_ctrl_mc;
  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       mem_rdy, resume;

  logic       rf_we, wb_sel, rb_sel, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, halted;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [15:0] instr_cnt;

  logic       s_rf_we, s_wb_sel, s_rb_sel, s_dm_we, s_ir_load, s_pc_write, s_pc_sel, s_br_sel, s_pc_rst, s_halted;
  logic [1:0] s_alu_op;
  logic [2:0] s_state;
  logic [1:0] s_instr_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_mc dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_rdy(mem_rdy), .resume(resume), .rf_we(rf_we), .wb_sel(wb_sel),
    .rb_sel(rb_sel), .alu_op(alu_op), .dm_we(dm_we), .ir_load(ir_load),
    .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel), .pc_rst(pc_rst),
    .halted(halted), .state(state), .instr_cnt(instr_cnt)
  );

  ctrl_mc #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_rdy(mem_rdy), .resume(resume), .rf_we(s_rf_we), .wb_sel(s_wb_sel),
    .rb_sel(s_rb_sel), .alu_op(s_alu_op), .dm_we(s_dm_we), .ir_load(s_ir_load),
    .pc_write(s_pc_write), .pc_sel(s_pc_sel), .br_sel(s_br_sel), .pc_rst(s_pc_rst),
    .halted(s_halted), .state(s_state), .instr_cnt(s_instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock, then let inputs/outputs settle away from the edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // from FETCH with mem_rdy=1, run the loaded instruction back to FETCH
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m);
    int n;
    opcode  = op;
    mm      = m;
    mem_rdy = 1'b1;
    n = 0;
    cyc();
    while (state != 3'd2 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) chk("run_instr_timeout", {29'd0, state}, 32'd2);
  endtask

  initial begin
    rst_f = 1'b1; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_rdy = 1'b1; resume = 1'b0;
    #3;
    chk("rst_state", state, 3'd1);
    chk("rst_pc_rst", pc_rst, 1'b1);
    chk("rst_alu_op", alu_op, 2'b10);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cnt", instr_cnt, 16'd0);
    cyc(); cyc();
    rst_f = 1'b0;
    cyc();
    chk("start_to_fetch", state, 3'd2);

    // ALU add
    opcode = 4'd8; mm = 4'd0; #1;
    chk("add_fetch_ir_load", ir_load, 1'b1);
    chk("add_fetch_pc_write", pc_write, 1'b1);
    chk("add_fetch_rf_we", rf_we, 1'b0);
    cyc(); chk("add_decode", state, 3'd3); chk("add_dec_pc_write", pc_write, 1'b0);
    chk("add_dec_rf_we", rf_we, 1'b0);
    cyc(); chk("add_exec", state, 3'd4); chk("add_exec_alu", alu_op, 2'b00);
    chk("add_exec_rf_we", rf_we, 1'b0);
    cyc(); chk("add_mem", state, 3'd5); chk("add_mem_alu", alu_op, 2'b10);
    chk("add_mem_rf_we", rf_we, 1'b0);
    cyc(); chk("add_wb", state, 3'd6); chk("add_wb_rf_we", rf_we, 1'b1);
    chk("add_wb_wb_sel", wb_sel, 1'b0);
    cyc(); chk("add_back_fetch", state, 3'd2); chk("add_cnt", instr_cnt, 16'd1);

    // ADDI
    mm = 4'd8;
    cyc(); cyc(); chk("addi_exec_alu", alu_op, 2'b01);
    cyc(); chk("addi_mem_alu", alu_op, 2'b11);
    cyc(); chk("addi_wb_alu", alu_op, 2'b11); chk("addi_wb_rf_we", rf_we, 1'b1);
    cyc(); chk("addi_cnt", instr_cnt, 16'd2);

    // BRA taken / not taken
    opcode = 4'd4; mm = 4'b0010; stat = 4'b0010;
    cyc(); chk("bra_t_pc_write", pc_write, 1'b1); chk("bra_t_pc_sel", pc_sel, 1'b1);
    chk("bra_t_br_sel", br_sel, 1'b1);
    run_instr(4'd4, 4'b0010);
    stat = 4'b0100;
    cyc(); chk("bra_nt_pc_write", pc_write, 1'b0);
    run_instr(4'd4, 4'b0010);

    // BNR taken, relative
    stat = 4'b0000;
    opcode = 4'd7; mm = 4'b0001;
    cyc(); chk("bnr_pc_write", pc_write, 1'b1); chk("bnr_pc_sel", pc_sel, 1'b1);
    chk("bnr_br_sel", br_sel, 1'b0);
    run_instr(4'd7, 4'b0001);
    chk("branch_cnt", instr_cnt, 16'd5);

    // FETCH stall
    opcode = 4'd0; mm = 4'd0; mem_rdy = 1'b0; #1;
    chk("fstall_ir_load0", ir_load, 1'b0); chk("fstall_pc_write0", pc_write, 1'b0);
    cyc(); chk("fstall_state1", state, 3'd2); chk("fstall_ir_load1", ir_load, 1'b0);
    cyc(); chk("fstall_state2", state, 3'd2);
    mem_rdy = 1'b1; #1; chk("fstall_release", ir_load, 1'b1);
    run_instr(4'd0, 4'd0);

    // LOD
    opcode = 4'd1; mm = 4'd3;
    cyc(); cyc(); chk("lod_exec_alu", alu_op, 2'b11); chk("lod_exec_rb_sel", rb_sel, 1'b0);
    cyc(); chk("lod_mem_alu", alu_op, 2'b11); chk("lod_mem_dm_we", dm_we, 1'b0);
    cyc(); chk("lod_wb_state", state, 3'd6); chk("lod_wb_rf_we", rf_we, 1'b1);
    chk("lod_wb_wb_sel", wb_sel, 1'b1);
    cyc(); chk("lod_cnt", instr_cnt, 16'd7);

    // STR with three MEM wait cycles
    opcode = 4'd2;
    cyc(); cyc(); chk("str_exec_rb_sel", rb_sel, 1'b1); chk("str_exec_dm_we", dm_we, 1'b0);
    cyc(); mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("str_wait_state", state, 3'd5);
      chk("str_wait_dm_we", dm_we, 1'b1);
      chk("str_wait_rb_sel", rb_sel, 1'b1);
      cyc();
    end
    mem_rdy = 1'b1; #1;
    chk("str_last_state", state, 3'd5); chk("str_last_dm_we", dm_we, 1'b1);
    cyc(); chk("str_wb_state", state, 3'd6); chk("str_wb_rf_we", rf_we, 1'b0);
    chk("str_wb_dm_we", dm_we, 1'b0);
    cyc();

    // HLT and resume
    opcode = 4'd15;
    cyc(); cyc(); chk("hlt_state", state, 3'd7);
    for (int i = 0; i < 10; i++) begin
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_no_pc_write", pc_write, 1'b0);
      cyc();
    end
    chk("hlt_still", state, 3'd7);
    resume = 1'b1;
    cyc(); resume = 1'b0;
    chk("resume_state", state, 3'd2); chk("resume_halted", halted, 1'b0);
    chk("hlt_cnt", instr_cnt, 16'd9);

    // async reset in the middle of a STR memory wait
    opcode = 4'd2;
    cyc(); cyc(); cyc(); mem_rdy = 1'b0; #1;
    chk("abort_pre_dm_we", dm_we, 1'b1);
    #1 rst_f = 1'b1; #1;
    chk("abort_state", state, 3'd1); chk("abort_dm_we", dm_we, 1'b0);
    chk("abort_cnt", instr_cnt, 16'd0); chk("abort_rf_we", rf_we, 1'b0);
    mem_rdy = 1'b1;
    cyc(); chk("abort_hold", state, 3'd1); chk("abort_hold_dm_we", dm_we, 1'b0);
    rst_f = 1'b0;
    cyc(); chk("abort_fetch", state, 3'd2);

    // counter saturation
    for (int i = 0; i < 3; i++) run_instr(4'd0, 4'd0);
    chk("sat_cnt3", s_instr_cnt, 2'd3);
    run_instr(4'd0, 4'd0);
    run_instr(4'd0, 4'd0);
    chk("sat_main_cnt", instr_cnt, 16'd5);
    chk("sat_cnt5", s_instr_cnt, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
